gate_array_pipe: RTL

GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

---
 rtl/gate_pkg.sv | 24 ++
 rtl/gate_array_comb.sv | 51 +++++
 rtl/gate_array_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// +------------------------------------------------------------------+
// | gate_pkg : opcode encoding shared by the gate array and its users |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_XNOR = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } gate_op_e;

    localparam int OP_W = 3;

endpackage

`default_nettype wire

// File: rtl/gate_array_comb.sv
// +------------------------------------------------------------------+
// | gate_array_comb : bitwise gate select plus result reductions     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gate_array_comb
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [WIDTH-1:0]  result_o,
    output logic              all_o,
    output logic              any_o,
    output logic              par_o,
    output logic [ONES_W-1:0] ones_o
);

    always_comb begin
        result_o = '0;
        case (gate_op_e'(op_i))
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_NOT:  result_o = ~a_i;
            OP_BUF:  result_o = a_i;
            default: result_o = '0;
        endcase
    end

    assign all_o = &result_o;
    assign any_o = |result_o;
    assign par_o = ^result_o;

    always_comb begin
        ones_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_o = ones_o + ONES_W'(result_o[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/gate_array_pipe.sv
// +------------------------------------------------------------------+
// | gate_array_pipe : one-stage valid/ready gate array with           |
// | accumulator feedback and a saturating transfer counter. Rev 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0,
    parameter int               CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [OP_W-1:0]              op,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic                         y_all,
    output logic                         y_any,
    output logic                         y_par,
    output logic [$clog2(WIDTH+1)-1:0]   y_ones,
    output logic [CNT_W-1:0]             xfer_cnt
);

    localparam int ONES_W = $clog2(WIDTH + 1);

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              all_q, all_d;
    logic              any_q, any_d;
    logic              par_q, par_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  res;
    logic              res_all, res_any, res_par;
    logic [ONES_W-1:0] res_ones;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign b_eff    = acc_en ? acc_q : b;

    gate_array_comb #(
        .WIDTH  (WIDTH),
        .ONES_W (ONES_W)
    ) u_comb (
        .a_i      (a),
        .b_i      (b_eff),
        .op_i     (op),
        .result_o (res),
        .all_o    (res_all),
        .any_o    (res_any),
        .par_o    (res_par),
        .ones_o   (res_ones)
    );

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        all_d   = all_q;
        any_d   = any_q;
        par_d   = par_q;
        ones_d  = ones_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        if (accept) begin
            valid_d = 1'b1;
            y_d     = res;
            all_d   = res_all;
            any_d   = res_any;
            par_d   = res_par;
            ones_d  = res_ones;
            acc_d   = res;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // Clear overrides the accept load; the result above already used the old value.
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end

        if (valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            all_q   <= 1'b0;
            any_q   <= 1'b0;
            par_q   <= 1'b0;
            ones_q  <= '0;
            acc_q   <= ACC_INIT;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            all_q   <= all_d;
            any_q   <= any_d;
            par_q   <= par_d;
            ones_q  <= ones_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign y_all     = all_q;
    assign y_any     = any_q;
    assign y_par     = par_q;
    assign y_ones    = ones_q;
    assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire
